cnorm_bfp: RTL and testbench
============================

// Module: cnorm_bfp
// PURPOSE
//  Parametrised successor of the FFT-output normalization stage. Per-frame complex left-shift
//  normaliser with correct per-sample overflow detection, optional saturation, and a sticky
//  per-frame overflow report. Sits after the last butterfly stage and before the output buffer.
//  SHIFT is latched once per frame, so every sample in a frame is scaled by the same amount.
// PARAMETERS
//  IW     19  input word width per component (two's complement)
//  OW     18  output word width per component; OW <= IW
//  MAXSH  3   maximum left shift; SW = clog2(MAXSH+1) is the SHIFT width
//  NFFT   64  samples per frame (START to START)
//  SAT_EN 1   1 = saturate on overflow; 0 = wrap (plain truncation)
// PORTS
//  CLK      in   1   clock; all logic on rising edge
//  RST      in   1   synchronous reset, active high
//  ED       in   1   enable; when 0, all state and outputs hold
//  START    in   1   first sample of a frame; qualified by ED
//  SHIFT    in   SW  shift amount; sampled only when ED && START
//  DR, DI   in   IW  real / imag input sample
//  DOR, DOI out  OW  normalised real / imag output
//  RDY      out  1   START delayed by one ED cycle; marks the first output of a frame
//  OVF      out  1   per-sample overflow flag, aligned with DOR/DOI
//  FRM_VLD  out  1   one-cycle pulse with the output of sample NFFT-1 of a frame
//  FRM_OVF  out  1   sticky OR of OVF over the frame; valid and held from FRM_VLD
// BEHAVIOUR
//  Reset: DOR=DOI=0, RDY=OVF=FRM_VLD=FRM_OVF=0, sample counter=0, latched shift=0, idle (no frame).
//  Shift select: sh = START ? SHIFT : sh_latched. A value of SHIFT > MAXSH is clamped to MAXSH.
//  Arithmetic, per component, for each ED cycle:
//   - w = D <<< sh, computed in IW bits.
//   - ovf_c = bits D[IW-1 : IW-1-sh] are not all equal (sh=0 gives ovf_c=0).
//   - If ovf_c && SAT_EN: w = D[IW-1] ? -2^(IW-1) : 2^(IW-1)-1.
//   - Output = w[IW-1 : IW-OW], truncated toward -inf, with no rounding.
//  Latency: exactly 1 ED-qualified cycle from D to DOR/DOI/OVF. OVF = ovf_r | ovf_i.
//  Frame FSM:
//   - States: IDLE -> RUN when ED && START.
//   - RUN counts 0..NFFT-1 and returns to IDLE after sample NFFT-1.
//   - When ED && START: latch SHIFT, counter = 1, accumulator = this sample's ovf.
//   - In RUN, each ED cycle: counter++ and accumulator |= ovf.
//   - On sample NFFT-1: the next cycle gives FRM_VLD=1 and FRM_OVF = accumulator including that
//     sample. FRM_OVF holds until the next FRM_VLD.
//  Boundary conditions:
//   - START in mid-frame: abort the current frame (no FRM_VLD for it) and begin a new frame on
//     that sample. Its data is still output normally.
//   - START coincident with sample NFFT-1: treat as a new frame; the old frame's FRM_VLD is
//     suppressed.
//   - Samples in IDLE without START: data is normalised with sh_latched; OVF is reported but not
//     accumulated.
//   - ED=0 at any point: freezes the counter, accumulator, outputs and pulses. FRM_VLD and RDY
//     stay high until the next ED cycle.
//   - RST mid-frame: abort; no FRM_VLD.
// TESTING
//  1 IW=19,OW=18: SHIFT=2 with START, DR=256, DI=-256 -> next cycle DOR=512, DOI=-512, OVF=0, RDY=1.
//  2 SHIFT=2, DR=65536, SAT_EN=1 -> OVF=1, DOR=131071 (0x1FFFF); DR=-65537 -> OVF=1, DOR=-131072.
//  3 Same as 2 with SAT_EN=0 -> OVF=1, DOR = wrapped truncation (65536<<2 -> 0x40000 -> DOR=-131072).
//  4 Frame of 64 clean samples, one overflow at sample 40 -> FRM_VLD pulse 1 cycle after sample 63,
//    FRM_OVF=1. Next clean frame -> FRM_OVF=0.
//  5 START reasserted at sample 30 -> no FRM_VLD for the aborted frame; FRM_VLD arrives 64 samples
//    after the new START. SHIFT changes mid-frame are ignored.
//  6 ED toggled 50% random plus RST asserted at sample 20 -> outputs match the model on ED cycles
//    only; after RST all outputs are 0 and no FRM_VLD is produced.

Source files
------------

// File: rtl/cnorm_bfp.sv
// ---------------------------------------------------------------------------
// cnorm_bfp
//
// Per-frame complex left-shift normaliser for FFT output data. Both components
// of every sample are shifted left by a shift amount that is latched once per
// frame, which keeps the block-floating-point exponent uniform across a frame.
// Overflow is detected per sample and can optionally saturate. The overflow
// flags of a frame are ORed into a sticky report that comes out with the last
// sample of the frame.
//
// Ports
//   i_clk         clock, all logic on the rising edge
//   i_rst         synchronous reset, active high
//   i_ed          enable; when low every register holds its value
//   i_start       first sample of a frame (qualified by i_ed)
//   i_shift       shift amount, sampled only on i_ed && i_start
//   i_dr, i_di    real / imaginary input sample, two's complement, IW bits
//   o_dor, o_doi  normalised real / imaginary output, OW bits
//   o_rdy         i_start delayed by one enabled cycle
//   o_ovf         per-sample overflow flag, aligned with o_dor/o_doi
//   o_frm_vld     one-cycle pulse with the output of sample NFFT-1
//   o_frm_ovf     sticky OR of o_ovf over the frame, held until the next pulse
// ---------------------------------------------------------------------------
module cnorm_bfp #(
  parameter  int IW     = 19,
  parameter  int OW     = 18,
  parameter  int MAXSH  = 3,
  parameter  int NFFT   = 64,
  parameter  int SAT_EN = 1,
  localparam int SW     = $clog2(MAXSH + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_ed,
  input  logic                 i_start,
  input  logic [SW-1:0]        i_shift,
  input  logic signed [IW-1:0] i_dr,
  input  logic signed [IW-1:0] i_di,
  output logic signed [OW-1:0] o_dor,
  output logic signed [OW-1:0] o_doi,
  output logic                 o_rdy,
  output logic                 o_ovf,
  output logic                 o_frm_vld,
  output logic                 o_frm_ovf
);

  localparam int            CW     = (NFFT > 1) ? $clog2(NFFT) : 1;
  localparam logic [CW-1:0] LAST   = CW'(NFFT - 1);
  localparam logic [SW-1:0] SH_MAX = SW'(MAXSH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_acc;
  logic          w_acc_nxt;
  logic          w_vld_nxt;
  logic          w_frm_ovf_nxt;
  logic [SW-1:0] r_sh;
  logic [SW-1:0] w_sh_clamped;
  logic [SW-1:0] w_sh;
  logic [OW:0]   w_nr;
  logic [OW:0]   w_ni;
  logic          w_ovf;

  // Normalise one component. The shifted value is shifted back arithmetically;
  // if that does not reproduce the input, some of the top sh+1 input bits
  // differed and the shift lost the sign. Returns {ovf, output word}; the
  // output word is the top OW bits of the IW-bit result (floor truncation).
  function automatic logic [OW:0] norm(input logic signed [IW-1:0] d,
                                       input logic [SW-1:0]        sh);
    logic signed [IW-1:0] w;
    logic signed [IW-1:0] back;
    logic                 ovf;
    w    = d <<< sh;
    back = w >>> sh;
    ovf  = (back != d);
    if (ovf && (SAT_EN != 0))
      w = d[IW-1] ? {1'b1, {(IW-1){1'b0}}} : {1'b0, {(IW-1){1'b1}}};
    return {ovf, w[IW-1:IW-OW]};
  endfunction

  // Shift selection: a START sample already uses its own (clamped) SHIFT,
  // every other sample uses the value latched at the last START.
  always_comb begin
    w_sh_clamped = ({1'b0, i_shift} > {1'b0, SH_MAX}) ? SH_MAX : i_shift;
    w_sh         = i_start ? w_sh_clamped : r_sh;
    w_nr         = norm(i_dr, w_sh);
    w_ni         = norm(i_di, w_sh);
    w_ovf        = w_nr[OW] | w_ni[OW];
  end

  // Frame tracking next-state logic. START always wins, which covers both the
  // mid-frame restart and a START landing on sample NFFT-1 (the old frame's
  // pulse is simply never generated). Samples outside a frame are normalised
  // but their overflow is not accumulated.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_acc_nxt     = r_acc;
    w_vld_nxt     = 1'b0;
    w_frm_ovf_nxt = o_frm_ovf;
    if (i_start) begin
      w_state_nxt = RUN;
      w_cnt_nxt   = CW'(1);
      w_acc_nxt   = w_ovf;
    end else if (r_state == RUN) begin
      if (r_cnt == LAST) begin
        w_state_nxt   = IDLE;
        w_cnt_nxt     = '0;
        w_acc_nxt     = 1'b0;
        w_vld_nxt     = 1'b1;
        w_frm_ovf_nxt = r_acc | w_ovf;
      end else begin
        w_cnt_nxt = r_cnt + CW'(1);
        w_acc_nxt = r_acc | w_ovf;
      end
    end
  end

  // Frame state register. Only enabled cycles advance it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else if (i_ed) begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and frame bookkeeping registers. With i_ed low everything,
  // including the one-cycle pulses, holds until the next enabled cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_acc     <= 1'b0;
      r_sh      <= '0;
      o_dor     <= '0;
      o_doi     <= '0;
      o_rdy     <= 1'b0;
      o_ovf     <= 1'b0;
      o_frm_vld <= 1'b0;
      o_frm_ovf <= 1'b0;
    end else if (i_ed) begin
      r_cnt     <= w_cnt_nxt;
      r_acc     <= w_acc_nxt;
      r_sh      <= w_sh;
      o_dor     <= w_nr[OW-1:0];
      o_doi     <= w_ni[OW-1:0];
      o_rdy     <= i_start;
      o_ovf     <= w_ovf;
      o_frm_vld <= w_vld_nxt;
      o_frm_ovf <= w_frm_ovf_nxt;
    end
  end

endmodule

// File: tb/tb_cnorm_bfp.sv
// ---------------------------------------------------------------------------
// tb_cnorm_bfp
//
// Directed bench for cnorm_bfp. Two instances share all inputs: dut uses
// saturation, dutWrap uses plain wrap-around truncation. Each scenario task
// drives its vectors and compares against hand-computed values.
// ---------------------------------------------------------------------------
module tb_cnorm_bfp;

  localparam int IW   = 19;
  localparam int OW   = 18;
  localparam int NFFT = 64;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 ed;
  logic                 start;
  logic [1:0]           shift;
  logic signed [IW-1:0] dr;
  logic signed [IW-1:0] di;

  logic signed [OW-1:0] dor, doi, dorW, doiW;
  logic                 rdy, ovf, fv, fo;
  logic                 rdyW, ovfW, fvW, foW;

  int nVec  = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  cnorm_bfp #(.IW(IW), .OW(OW), .MAXSH(3), .NFFT(NFFT), .SAT_EN(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_ed(ed), .i_start(start), .i_shift(shift),
    .i_dr(dr), .i_di(di), .o_dor(dor), .o_doi(doi), .o_rdy(rdy), .o_ovf(ovf),
    .o_frm_vld(fv), .o_frm_ovf(fo)
  );

  cnorm_bfp #(.IW(IW), .OW(OW), .MAXSH(3), .NFFT(NFFT), .SAT_EN(0)) dutWrap (
    .i_clk(clk), .i_rst(rst), .i_ed(ed), .i_start(start), .i_shift(shift),
    .i_dr(dr), .i_di(di), .o_dor(dorW), .o_doi(doiW), .o_rdy(rdyW), .o_ovf(ovfW),
    .o_frm_vld(fvW), .o_frm_ovf(foW)
  );

  // Apply one input vector and return 1 ns after the rising edge that
  // captured it, so the outputs now show that sample.
  task automatic drive(input logic e, input logic s, input logic [1:0] sh,
                       input int r, input int im);
    ed    = e;
    start = s;
    shift = sh;
    dr    = r[IW-1:0];
    di    = im[IW-1:0];
    @(posedge clk);
    #1;
  endtask

  // Reset clears every output.
  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 1'b1, 2'd3, 1000, 1000);
    drive(1'b1, 1'b0, 2'd0, 0, 0);
    nVec++; if (dor !== '0) begin nFail++; $display("[TB] FAIL reset_dor: got %0d expected 0", dor); end
    nVec++; if (doi !== '0) begin nFail++; $display("[TB] FAIL reset_doi: got %0d expected 0", doi); end
    nVec++; if (rdy !== 1'b0) begin nFail++; $display("[TB] FAIL reset_rdy: got %b expected 0", rdy); end
    nVec++; if (ovf !== 1'b0) begin nFail++; $display("[TB] FAIL reset_ovf: got %b expected 0", ovf); end
    nVec++; if (fv !== 1'b0) begin nFail++; $display("[TB] FAIL reset_frm_vld: got %b expected 0", fv); end
    nVec++; if (fo !== 1'b0) begin nFail++; $display("[TB] FAIL reset_frm_ovf: got %b expected 0", fo); end
    rst = 1'b0;
  endtask

  // Plain shift by 2, then a non-START sample that must reuse the latched shift.
  task automatic test_basic();
    drive(1'b1, 1'b1, 2'd2, 256, -256);
    nVec++; if (dor !== OW'(512)) begin nFail++; $display("[TB] FAIL basic_dor: got %0d expected 512", dor); end
    nVec++; if (doi !== OW'(-512)) begin nFail++; $display("[TB] FAIL basic_doi: got %0d expected -512", doi); end
    nVec++; if (ovf !== 1'b0) begin nFail++; $display("[TB] FAIL basic_ovf: got %b expected 0", ovf); end
    nVec++; if (rdy !== 1'b1) begin nFail++; $display("[TB] FAIL basic_rdy: got %b expected 1", rdy); end
    drive(1'b1, 1'b0, 2'd0, -3, 3);
    nVec++; if (dor !== OW'(-6)) begin nFail++; $display("[TB] FAIL latched_dor: got %0d expected -6", dor); end
    nVec++; if (doi !== OW'(6)) begin nFail++; $display("[TB] FAIL latched_doi: got %0d expected 6", doi); end
    nVec++; if (rdy !== 1'b0) begin nFail++; $display("[TB] FAIL latched_rdy: got %b expected 0", rdy); end
  endtask

  // Dropping the LSB truncates toward minus infinity.
  task automatic test_truncate();
    drive(1'b1, 1'b1, 2'd0, -3, 3);
    nVec++; if (dor !== OW'(-2)) begin nFail++; $display("[TB] FAIL trunc_neg3: got %0d expected -2", dor); end
    nVec++; if (doi !== OW'(1)) begin nFail++; $display("[TB] FAIL trunc_pos3: got %0d expected 1", doi); end
    drive(1'b1, 1'b0, 2'd0, -1, 1);
    nVec++; if (dor !== OW'(-1)) begin nFail++; $display("[TB] FAIL trunc_neg1: got %0d expected -1", dor); end
    nVec++; if (doi !== OW'(0)) begin nFail++; $display("[TB] FAIL trunc_pos1: got %0d expected 0", doi); end
  endtask

  // Overflow with saturation (dut) and wrap-around (dutWrap); -65536<<2 just fits.
  task automatic test_saturate();
    drive(1'b1, 1'b1, 2'd2, 65536, 0);
    nVec++; if (dor !== OW'(131071)) begin nFail++; $display("[TB] FAIL sat_pos_dor: got %0d expected 131071", dor); end
    nVec++; if (ovf !== 1'b1) begin nFail++; $display("[TB] FAIL sat_pos_ovf: got %b expected 1", ovf); end
    nVec++; if (doi !== OW'(0)) begin nFail++; $display("[TB] FAIL sat_pos_doi: got %0d expected 0", doi); end
    nVec++; if (dorW !== OW'(-131072)) begin nFail++; $display("[TB] FAIL wrap_pos_dor: got %0d expected -131072", dorW); end
    nVec++; if (ovfW !== 1'b1) begin nFail++; $display("[TB] FAIL wrap_pos_ovf: got %b expected 1", ovfW); end
    drive(1'b1, 1'b0, 2'd0, -65537, -65536);
    nVec++; if (dor !== OW'(-131072)) begin nFail++; $display("[TB] FAIL sat_neg_dor: got %0d expected -131072", dor); end
    nVec++; if (ovf !== 1'b1) begin nFail++; $display("[TB] FAIL sat_neg_ovf: got %b expected 1", ovf); end
    nVec++; if (doi !== OW'(-131072)) begin nFail++; $display("[TB] FAIL exact_neg_doi: got %0d expected -131072", doi); end
    nVec++; if (dorW !== OW'(131070)) begin nFail++; $display("[TB] FAIL wrap_neg_dor: got %0d expected 131070", dorW); end
    nVec++; if (doiW !== OW'(-131072)) begin nFail++; $display("[TB] FAIL wrap_exact_doi: got %0d expected -131072", doiW); end
    drive(1'b1, 1'b0, 2'd0, 0, 32768);
    nVec++; if (ovf !== 1'b0) begin nFail++; $display("[TB] FAIL edge_ovf: got %b expected 0", ovf); end
    nVec++; if (doi !== OW'(65536)) begin nFail++; $display("[TB] FAIL edge_doi: got %0d expected 65536", doi); end
  endtask

  // Full frame with one overflow at sample 40, then clean frames; an
  // overflowing sample outside a frame must not reach the next report.
  task automatic test_frame();
    for (int k = 0; k < NFFT; k++) begin
      drive(1'b1, k == 0, 2'd2, (k == 40) ? 65536 : 100, -100);
      nVec++; if (fv !== (k == NFFT-1)) begin nFail++; $display("[TB] FAIL frame1_vld[%0d]: got %b expected %b", k, fv, k == NFFT-1); end
      if (k == 0) begin
        nVec++; if (rdy !== 1'b1) begin nFail++; $display("[TB] FAIL frame1_rdy: got %b expected 1", rdy); end
      end
      if (k == 10) begin
        nVec++; if (dor !== OW'(200)) begin nFail++; $display("[TB] FAIL frame1_dor: got %0d expected 200", dor); end
      end
      if (k == 40) begin
        nVec++; if (ovf !== 1'b1) begin nFail++; $display("[TB] FAIL frame1_ovf40: got %b expected 1", ovf); end
      end
    end
    nVec++; if (fo !== 1'b1) begin nFail++; $display("[TB] FAIL frame1_frm_ovf: got %b expected 1", fo); end
    for (int k = 0; k < NFFT; k++) begin
      drive(1'b1, k == 0, 2'd2, 100, -100);
      nVec++; if (fv !== (k == NFFT-1)) begin nFail++; $display("[TB] FAIL frame2_vld[%0d]: got %b expected %b", k, fv, k == NFFT-1); end
      if (k == 10) begin
        nVec++; if (fo !== 1'b1) begin nFail++; $display("[TB] FAIL frame2_hold: got %b expected 1", fo); end
      end
    end
    nVec++; if (fo !== 1'b0) begin nFail++; $display("[TB] FAIL frame2_frm_ovf: got %b expected 0", fo); end
    drive(1'b1, 1'b0, 2'd0, 65536, 0);
    nVec++; if (ovf !== 1'b1) begin nFail++; $display("[TB] FAIL idle_ovf: got %b expected 1", ovf); end
    nVec++; if (fv !== 1'b0) begin nFail++; $display("[TB] FAIL idle_vld: got %b expected 0", fv); end
    for (int k = 0; k < NFFT; k++) begin
      drive(1'b1, k == 0, 2'd2, 100, -100);
      nVec++; if (fv !== (k == NFFT-1)) begin nFail++; $display("[TB] FAIL frame3_vld[%0d]: got %b expected %b", k, fv, k == NFFT-1); end
    end
    nVec++; if (fo !== 1'b0) begin nFail++; $display("[TB] FAIL frame3_frm_ovf: got %b expected 0", fo); end
  endtask

  // Restart at sample 30; SHIFT wiggling mid-frame must not change the scale.
  task automatic test_abort();
    for (int k = 0; k < 30; k++) begin
      drive(1'b1, k == 0, (k == 0) ? 2'd1 : 2'd3, 100, 0);
      nVec++; if (dor !== OW'(100)) begin nFail++; $display("[TB] FAIL abort_dor[%0d]: got %0d expected 100", k, dor); end
      nVec++; if (fv !== 1'b0) begin nFail++; $display("[TB] FAIL abort_old_vld[%0d]: got %b expected 0", k, fv); end
    end
    for (int k = 0; k < NFFT; k++) begin
      drive(1'b1, k == 0, (k == 0) ? 2'd1 : 2'd2, 100, 0);
      nVec++; if (fv !== (k == NFFT-1)) begin nFail++; $display("[TB] FAIL abort_new_vld[%0d]: got %b expected %b", k, fv, k == NFFT-1); end
      if (k == 0) begin
        nVec++; if (rdy !== 1'b1) begin nFail++; $display("[TB] FAIL abort_rdy: got %b expected 1", rdy); end
      end
    end
  endtask

  // START landing on sample NFFT-1 of the running frame.
  task automatic test_start_last();
    for (int k = 0; k < NFFT-1; k++) drive(1'b1, k == 0, 2'd0, 5, 0);
    for (int k = 0; k < NFFT; k++) begin
      drive(1'b1, k == 0, 2'd0, 5, 0);
      nVec++; if (fv !== (k == NFFT-1)) begin nFail++; $display("[TB] FAIL startlast_vld[%0d]: got %b expected %b", k, fv, k == NFFT-1); end
    end
    nVec++; if (dor !== OW'(2)) begin nFail++; $display("[TB] FAIL startlast_dor: got %0d expected 2", dor); end
  endtask

  // Enable gating with a fixed irregular pattern, then reset mid-frame.
  task automatic test_ed_gating();
    logic [31:0] pat = 32'hB2E53AC6;
    int          s = 0;
    int          c = 0;
    int          expDor = 0;
    logic        expFv = 1'b0;
    logic        expRdy = 1'b0;
    logic        e;
    while (s < NFFT && c < 1000) begin
      e = (s == 0) ? 1'b1 : pat[c[4:0]];
      if (e) begin
        drive(1'b1, s == 0, 2'd0, 10 * s, 0);
        expDor = 5 * s;
        expFv  = (s == NFFT-1);
        expRdy = (s == 0);
        s++;
      end else begin
        drive(1'b0, 1'b0, 2'd3, 7777, 7777);
      end
      nVec++; if (dor !== OW'(expDor)) begin nFail++; $display("[TB] FAIL ed_dor[c%0d]: got %0d expected %0d", c, dor, expDor); end
      nVec++; if (fv !== expFv) begin nFail++; $display("[TB] FAIL ed_vld[c%0d]: got %b expected %b", c, fv, expFv); end
      nVec++; if (rdy !== expRdy) begin nFail++; $display("[TB] FAIL ed_rdy[c%0d]: got %b expected %b", c, rdy, expRdy); end
      c++;
    end
    nVec++; if (s != NFFT) begin nFail++; $display("[TB] FAIL ed_budget: got %0d samples expected %0d", s, NFFT); end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 2'd0, 1, 1);
      nVec++; if (fv !== 1'b1) begin nFail++; $display("[TB] FAIL ed_vld_hold[%0d]: got %b expected 1", k, fv); end
    end
    drive(1'b1, 1'b0, 2'd0, 0, 0);
    nVec++; if (fv !== 1'b0) begin nFail++; $display("[TB] FAIL ed_vld_drop: got %b expected 0", fv); end

    s = 0;
    c = 0;
    while (s < 20 && c < 1000) begin
      e = (s == 0) ? 1'b1 : pat[c[4:0]];
      drive(e, s == 0, 2'd2, 100, 100);
      if (e) s++;
      c++;
    end
    rst = 1'b1;
    drive(1'b1, 1'b0, 2'd0, 100, 100);
    rst = 1'b0;
    nVec++; if (dor !== '0) begin nFail++; $display("[TB] FAIL rst_mid_dor: got %0d expected 0", dor); end
    nVec++; if (doi !== '0) begin nFail++; $display("[TB] FAIL rst_mid_doi: got %0d expected 0", doi); end
    nVec++; if ({rdy, ovf, fv, fo} !== 4'b0) begin nFail++; $display("[TB] FAIL rst_mid_flags: got %b expected 0000", {rdy, ovf, fv, fo}); end
    for (int k = 0; k < NFFT + 4; k++) begin
      drive(1'b1, 1'b0, 2'd3, 100, 0);
      nVec++; if (fv !== 1'b0) begin nFail++; $display("[TB] FAIL rst_no_vld[%0d]: got %b expected 0", k, fv); end
    end
    nVec++; if (dor !== OW'(50)) begin nFail++; $display("[TB] FAIL rst_shift_cleared: got %0d expected 50", dor); end
  endtask

  // Scenario sequence and summary.
  initial begin
    rst   = 1'b1;
    ed    = 1'b0;
    start = 1'b0;
    shift = 2'd0;
    dr    = '0;
    di    = '0;
    test_reset();
    test_basic();
    test_truncate();
    test_saturate();
    test_frame();
    test_abort();
    test_start_last();
    test_ed_gating();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: got no completion expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
